// File: rtl/ad9361_spi_pkg.sv
// Shared types and header field layout for the AD9361-format SPI responder.
package ad9361_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WR,
        RD,
        DONE
    } state_t;

    localparam int HDR_BITS     = 16;
    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 8;

    localparam int HDR_WRN_BIT  = 15;
    localparam int HDR_NB_MSB   = 14;
    localparam int HDR_NB_LSB   = 12;
    localparam int HDR_ADDR_MSB = 9;

    // Multi-byte frames walk downwards through the 10-bit space and wrap 0x000 -> 0x3FF.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return a - ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ad9361_spi_slave_if.sv
// Parallel register-access port produced by the SPI responder.
interface ad9361_spi_slave_if;
    import ad9361_spi_pkg::*;

    // reg_wr_en and reg_rd_en are single-cycle strobes, never high together; reg_addr and
    // reg_wdata are valid in the strobe cycle; reg_rdata must be valid the cycle after reg_rd_en.
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [DATA_W-1:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_wr_en,
        output reg_rd_en,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_wr_en,
        input  reg_rd_en,
        output reg_rdata
    );

endinterface

// File: rtl/ad9361_spi_sync.sv
// Oversamples SCLK/CS/MOSI into sys_clk and produces registered edge pulses
// (SYNC_STAGES+1 cycles after the pin edge). SYNC_STAGES must be at least 2.
module ad9361_spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_nrst,
    input  logic spi_sclk,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_lvl,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic                   sclk_d;

    // CS resets to "selected" so a CS held low through reset is never seen as a fresh fall.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            sclk_ff   <= '0;
            cs_ff     <= '0;
            mosi_ff   <= '0;
            sclk_d    <= 1'b0;
            cs_lvl    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], spi_sclk};
            cs_ff     <= {cs_ff[SYNC_STAGES-2:0], spi_cs};
            mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_ff[SYNC_STAGES-1];
            cs_lvl    <= cs_ff[SYNC_STAGES-1];
            sclk_rise <= sclk_ff[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_ff[SYNC_STAGES-1] & sclk_d;
            cs_rise   <= cs_ff[SYNC_STAGES-1] & ~cs_lvl;
            cs_fall   <= ~cs_ff[SYNC_STAGES-1] & cs_lvl;
        end
    end

    assign mosi_s = mosi_ff[SYNC_STAGES-1];

endmodule

// File: rtl/ad9361_spi_slave.sv
// AD9361-format SPI responder: decodes 16-bit header + data bytes from oversampled SPI
// pins into register strobes on sys_clk, and serves read data back on MISO.
module ad9361_spi_slave
    import ad9361_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                sys_clk,
    input  logic                sys_nrst,
    input  logic                spi_cs,
    input  logic                spi_sclk,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    output logic                frame_done,
    output logic                frame_err,
    output state_t              dbg_state,
    ad9361_spi_slave_if.master  reg_bus
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_lvl, mosi_s;
    logic bit_fall, bit_rise;

    state_t              state_q, state_d;
    logic [3:0]          bit_cnt_q;
    logic [HDR_BITS-2:0] shreg_q;
    logic [HDR_BITS-1:0] rx_word;
    logic [2:0]          nb_left_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   tx_sh_q, rd_buf_q, wdata_q;
    logic                wr_en_q, cap_first_q, cap_next_q, tx_vld_q;
    logic                hdr_end, byte_end, rd_launch, in_frame;

    ad9361_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .sys_clk   (sys_clk),
        .sys_nrst  (sys_nrst),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .cs_lvl    (cs_lvl),
        .mosi_s    (mosi_s)
    );

    assign bit_fall = sclk_fall & ~cs_lvl;
    assign bit_rise = sclk_rise & ~cs_lvl;
    assign rx_word  = {shreg_q, mosi_s};
    assign in_frame = (state_q == HDR) || (state_q == WR) || (state_q == RD);
    assign hdr_end  = (state_q == HDR) && bit_fall && !cs_rise && (bit_cnt_q == 4'(HDR_BITS - 1));
    assign byte_end = ((state_q == WR) || (state_q == RD)) && bit_fall && !cs_rise
                      && (bit_cnt_q == 4'(DATA_W - 1));

    // Read requests are issued combinationally on the sampling edge so the returned byte
    // can be on MISO SYNC_STAGES+3 cycles after the SCLK edge.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        rd_launch  = 1'b0;
        rd_addr    = addr_q;
        case (state_q)
            IDLE: if (cs_fall) state_d = HDR;
            HDR: begin
                if (cs_rise) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else if (hdr_end) begin
                    rd_addr = rx_word[HDR_ADDR_MSB:0];
                    if (rx_word[HDR_WRN_BIT]) begin
                        state_d = WR;
                    end else begin
                        state_d   = RD;
                        rd_launch = 1'b1;
                    end
                end
            end
            WR: begin
                if (cs_rise) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else if (byte_end && nb_left_q == 3'd0) begin
                    state_d = DONE;
                end
            end
            RD: begin
                if (cs_rise) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else if (byte_end) begin
                    if (nb_left_q == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        rd_launch = 1'b1;
                        rd_addr   = next_addr(addr_q);
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            nb_left_q   <= '0;
            addr_q      <= '0;
            tx_sh_q     <= '0;
            rd_buf_q    <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            cap_first_q <= 1'b0;
            cap_next_q  <= 1'b0;
            tx_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= 1'b0;
            cap_first_q <= rd_launch && (state_q == HDR);
            cap_next_q  <= rd_launch && (state_q == RD);

            if (state_q == IDLE) begin
                bit_cnt_q <= '0;
                tx_vld_q  <= 1'b0;
            end
            if (bit_fall && in_frame) begin
                shreg_q   <= rx_word[HDR_BITS-2:0];
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (hdr_end) begin
                bit_cnt_q <= '0;
                nb_left_q <= rx_word[HDR_NB_MSB:HDR_NB_LSB];
                addr_q    <= rx_word[HDR_ADDR_MSB:0];
                tx_vld_q  <= 1'b0;
            end
            if (byte_end) begin
                bit_cnt_q <= '0;
                if (nb_left_q != 3'd0) nb_left_q <= nb_left_q - 3'd1;
                if (state_q == WR) begin
                    wdata_q <= rx_word[DATA_W-1:0];
                    wr_en_q <= 1'b1;
                end
            end
            if (rd_launch) addr_q <= rd_addr;
            if (wr_en_q && state_q == WR) addr_q <= next_addr(addr_q);

            if (cap_first_q) begin
                tx_sh_q  <= reg_bus.reg_rdata;
                rd_buf_q <= reg_bus.reg_rdata;
                tx_vld_q <= 1'b1;
            end
            if (cap_next_q) rd_buf_q <= reg_bus.reg_rdata;
            // First rise of each byte presents the buffered byte; the rest shift it out.
            if (bit_rise && state_q == RD && tx_vld_q) begin
                if (bit_cnt_q == 4'd0) tx_sh_q <= rd_buf_q;
                else                   tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign spi_miso_oe       = (state_q == RD) && tx_vld_q;
    assign spi_miso          = spi_miso_oe & tx_sh_q[DATA_W-1];
    assign reg_bus.reg_addr  = rd_launch ? rd_addr : addr_q;
    assign reg_bus.reg_wdata = wdata_q;
    assign reg_bus.reg_wr_en = wr_en_q;
    assign reg_bus.reg_rd_en = rd_launch;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_ad9361_spi_slave.sv
// Directed bench for ad9361_spi_slave: bit-banged SPI master, register-file model and
// immediate-assertion checks with hand-computed expectations.
module tb_ad9361_spi_slave;
    import ad9361_spi_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic   sys_clk  = 1'b0;
    logic   sys_nrst = 1'b0;
    logic   spi_cs   = 1'b1;
    logic   spi_sclk = 1'b0;
    logic   spi_mosi = 1'b0;
    logic   spi_miso, spi_miso_oe, frame_done, frame_err;
    state_t dbg_state;

    ad9361_spi_slave_if reg_bus ();

    ad9361_spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .sys_clk     (sys_clk),
        .sys_nrst    (sys_nrst),
        .spi_cs      (spi_cs),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .dbg_state   (dbg_state),
        .reg_bus     (reg_bus)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // register-file model: read data valid the cycle after reg_rd_en
    logic [7:0] mem [1024];
    always @(posedge sys_clk) begin
        if (reg_bus.reg_rd_en) reg_bus.reg_rdata <= mem[reg_bus.reg_addr];
    end

    // scoreboard state
    int          n_checks = 0;
    int          n_err    = 0;
    logic [17:0] exp_q[$];
    logic [17:0] wr_log[$];
    logic [9:0]  rd_log[$];
    int          done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int          wr_cyc = -1, done_cyc = -1, oe_cyc = -1;
    int          fall_last_cyc = 0, fall16_cyc = 0, cs_rise_cyc = 0, frame_bits = 0;
    logic        oe_prev = 1'b0;

    always @(negedge sys_clk) begin
        if (reg_bus.reg_wr_en) begin
            wr_log.push_back({reg_bus.reg_addr, reg_bus.reg_wdata});
            wr_cyc = cyc;
        end
        if (reg_bus.reg_rd_en) rd_log.push_back(reg_bus.reg_addr);
        if (reg_bus.reg_wr_en && reg_bus.reg_rd_en) both_cnt++;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_err) err_cnt++;
        if (spi_miso_oe && !oe_prev) oe_cyc = cyc;
        oe_prev = spi_miso_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, wr_log.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_log.size() > 0)
            chk(tag, wr_log.pop_front(), exp_q.pop_front());
        wr_log.delete();
        exp_q.delete();
    endtask

    // driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic cs_low();
        wait_clk(1);
        spi_cs     = 1'b0;
        frame_bits = 0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        spi_cs      = 1'b1;
        cs_rise_cyc = cyc;
    endtask

    task automatic shift_bits(input int n, input logic [63:0] tx, output logic [63:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            spi_sclk = 1'b1;
            wait_clk(HALF);
            rx            = {rx[62:0], spi_miso};
            spi_sclk      = 1'b0;
            fall_last_cyc = cyc;
            frame_bits++;
            if (frame_bits == 16) fall16_cyc = cyc;
            wait_clk(HALF);
        end
    endtask

    task automatic frame(input int n, input logic [63:0] tx, input int gap, output logic [63:0] rx);
        cs_low();
        shift_bits(n, tx, rx);
        cs_high();
        wait_clk(gap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [63:0] rx, rx2;

    initial begin
        mem[10'h037] = 8'h5A;
        mem[10'h000] = 8'hC3;
        mem[10'h3FF] = 8'h96;
        mem[10'h010] = 8'hAA;

        // reset values
        wait_clk(3);
        chk("rst_miso",  spi_miso, 0);
        chk("rst_oe",    spi_miso_oe, 0);
        chk("rst_addr",  reg_bus.reg_addr, 0);
        chk("rst_wdata", reg_bus.reg_wdata, 0);
        chk("rst_wr_en", reg_bus.reg_wr_en, 0);
        chk("rst_rd_en", reg_bus.reg_rd_en, 0);
        chk("rst_done",  frame_done, 0);
        chk("rst_err",   frame_err, 0);
        chk("rst_state", dbg_state, IDLE);
        sys_nrst = 1'b1;
        wait_clk(5);

        // single-byte write 0x0A5 <- 0x3C
        frame(24, {40'h0, 16'h80A5, 8'h3C}, 8, rx);
        exp_q.push_back({10'h0A5, 8'h3C});
        check_writes("wr1");
        chk("wr1_latency",   wr_cyc - fall_last_cyc, SYNC_STAGES + 2);
        chk("wr1_done",      done_cnt, 1);
        chk("wr1_done_lat",  done_cyc - cs_rise_cyc, SYNC_STAGES + 1);
        chk("wr1_no_oe",     oe_cyc, 32'hFFFF_FFFF);
        chk("wr1_no_reads",  rd_log.size(), 0);

        // single-byte read at 0x037, model returns 0x5A
        frame(24, {40'h0, 16'h0037, 8'h00}, 8, rx);
        chk("rd1_data",      rx[7:0], 8'h5A);
        chk("rd1_rd_count",  rd_log.size(), 1);
        if (rd_log.size() > 0) chk("rd1_addr", rd_log[0], 10'h037);
        chk("rd1_miso_lat",  (oe_cyc > fall16_cyc) && (oe_cyc - fall16_cyc <= SYNC_STAGES + 3), 1);
        chk("rd1_done",      done_cnt, 2);
        chk("rd1_oe_after",  spi_miso_oe, 0);
        rd_log.delete();
        wr_log.delete();

        // multi-byte write back-to-back with a two-byte read wrapping 0x000 -> 0x3FF
        frame(40, {24'h0, 16'hA100, 24'h112233}, 1, rx);
        frame(32, {32'h0, 16'h1000, 16'h0000}, 8, rx2);
        exp_q.push_back({10'h100, 8'h11});
        exp_q.push_back({10'h0FF, 8'h22});
        exp_q.push_back({10'h0FE, 8'h33});
        check_writes("wr3");
        chk("rd2_data",      rx2[15:0], 16'hC396);
        chk("rd2_rd_count",  rd_log.size(), 2);
        if (rd_log.size() > 1) begin
            chk("rd2_addr0", rd_log[0], 10'h000);
            chk("rd2_addr1", rd_log[1], 10'h3FF);
        end
        chk("b2b_done",      done_cnt, 4);
        chk("b2b_err",       err_cnt, 0);
        rd_log.delete();

        // aborts: after 10 header bits, then after 20 bits of a write frame
        cs_low();
        shift_bits(10, 64'h202, rx);
        cs_high();
        wait_clk(8);
        chk("abort1_err",    err_cnt, 1);
        cs_low();
        shift_bits(20, {44'h0, 16'h8123, 4'hF}, rx);
        cs_high();
        wait_clk(8);
        chk("abort2_err",    err_cnt, 2);
        chk("abort_done",    done_cnt, 4);
        check_writes("abort_wr");
        frame(24, {40'h0, 16'h8055, 8'h77}, 8, rx);
        exp_q.push_back({10'h055, 8'h77});
        check_writes("post_abort_wr");
        chk("post_abort_done", done_cnt, 5);

        // reset asserted in the middle of a read data phase
        cs_low();
        shift_bits(19, {45'h0, 16'h0010, 3'b000}, rx);
        chk("mid_rd_oe",     spi_miso_oe, 1);
        chk("mid_rd_bits",   rx[2:0], 3'b101);
        sys_nrst = 1'b0;
        #1;
        chk("rst_mid_oe",    spi_miso_oe, 0);
        chk("rst_mid_state", dbg_state, IDLE);
        chk("rst_mid_addr",  reg_bus.reg_addr, 0);
        wait_clk(2);
        sys_nrst = 1'b1;
        wait_clk(3);
        cs_high();
        wait_clk(8);
        chk("rst_mid_done",  done_cnt, 5);
        chk("rst_mid_err",   err_cnt, 2);
        rd_log.delete();
        frame(24, {40'h0, 16'h83FF, 8'hE7}, 8, rx);
        exp_q.push_back({10'h3FF, 8'hE7});
        check_writes("post_rst_wr");
        chk("post_rst_done", done_cnt, 6);
        chk("strobe_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ad9361_spi_slave.md
# ad9361_spi_slave

SPI responder that receives AD9361-format 3-wire-style 24+ bit register frames (CPOL=0, MSB first) from an SPI master and converts them into a parallel register-access port on `sys_clk`. It also returns read data on MISO. It sits on the far side of the SPI link from our AD9361 SPI driver and serves as a bench-side AD9361 register model and as the front end of FPGA-hosted register maps. SCLK, CS and MOSI are oversampled in the `sys_clk` domain, so no SCLK-clocked logic is used.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_sclk`, `spi_cs` and `spi_mosi`. Minimum value is 2.
- `sys_clk`  in  1  block clock. SCLK half-period must be ≥ 5 `sys_clk` cycles.
- `sys_nrst`  in  1  asynchronous, active-low reset.
- `spi_cs`  in  1  chip select, active low.
- `spi_sclk`  in  1  SPI clock. Idles low.
- `spi_mosi`  in  1  serial data from the master.
- `spi_miso`  out  1  serial read data to the master.
- `spi_miso_oe`  out  1  MISO output enable. High only during the read data phase.
- `reg_addr`  out  10  register address for the current byte.
- `reg_wdata`  out  8  write data. Valid while `reg_wr_en` is high.
- `reg_wr_en`  out  1  one-cycle write strobe.
- `reg_rd_en`  out  1  one-cycle read request.
- `reg_rdata`  in  8  read data. Must be valid exactly 1 cycle after `reg_rd_en`.
- `frame_done`  out  1  one-cycle pulse on a clean frame end.
- `frame_err`  out  1  one-cycle pulse on a frame aborted by CS.

## Operation
- Header is 16 bits, MSB first:
  - bit15: W/Rn, where 1 = write.
  - bits14:12: NB, so the frame carries NB+1 data bytes.
  - bits11:10: reserved. Ignored.
  - bits9:0: start address.
- Data phase is (NB+1)×8 bits.
- Sampling rules: MOSI is sampled on synchronized SCLK falling edges. MISO changes on synchronized SCLK rising edges.
- Address sequencing: byte k uses address start−k, modulo 1024. So 0x000 decrements to 0x3FF.
- FSM states:
  - IDLE: waiting for CS to fall.
    - CS falls → HDR. Clear the bit counter.
  - HDR: shift in 16 bits.
    - After the 16th falling edge, latch W/Rn, NB and address.
    - If W/Rn = 1 → WR.
    - If W/Rn = 0, pulse `reg_rd_en`, capture `reg_rdata` next cycle into the TX shifter, then → RD.
  - WR: shift in 8 bits.
    - On the 8th falling edge, present `reg_addr`/`reg_wdata` and pulse `reg_wr_en`.
    - If bytes remain, decrement the address and stay in WR.
    - Otherwise → DONE.
  - RD: drive `spi_miso` = TX bit7 with `spi_miso_oe` = 1 from the header-end capture.
    - Shift on each rising edge.
    - On each byte's 8th falling edge, if bytes remain, decrement the address and pulse `reg_rd_en` for the next byte. The reloaded byte appears on the next rising edge.
    - Otherwise → DONE.
  - DONE: ignore further SCLK edges.
    - CS rises → pulse `frame_done` → IDLE.
- CS rises in HDR, WR or RD → pulse `frame_err`, drop `spi_miso_oe`, → IDLE. A partial byte is never written.
- SCLK edges while CS is high are ignored.
- `reg_wr_en` and `reg_rd_en` are never high in the same cycle.

## Timing
- Reset values:
  - `spi_miso`=0, `spi_miso_oe`=0.
  - `reg_addr`=0, `reg_wdata`=0.
  - `reg_wr_en`=0, `reg_rd_en`=0.
  - `frame_done`=0, `frame_err`=0.
  - FSM in IDLE.
- Edge-detect latency is SYNC_STAGES+1 `sys_clk` cycles from the pin edge.
- `reg_wr_en` asserts SYNC_STAGES+2 cycles after the final SCLK falling edge of the byte.
- Read turnaround: `reg_rd_en` → `reg_rdata` capture takes 1 cycle. MISO bit7 is driven no later than SYNC_STAGES+3 cycles after the 16th falling edge. It is therefore stable before the master samples on the next falling edge, given the half-period rule.
- `frame_done`/`frame_err` assert SYNC_STAGES+1 cycles after CS rises.
- Back-to-back frames: CS may fall again 2 `sys_clk` cycles after rising. That new fall is accepted.
- Reset asserted mid-frame returns everything to reset values immediately. The next frame starts only on a fresh CS fall.

## Structure
- Package `ad9361_spi_pkg`:
  - FSM state enum (IDLE, HDR, WR, RD, DONE).
  - `HDR_BITS`=16, `ADDR_W`=10, `DATA_W`=8.
  - Header field positions (`HDR_WRN_BIT`=15, `HDR_NB_MSB`/`LSB`=14/12, `HDR_ADDR_MSB`=9).
- Sub-module `ad9361_spi_sync`: SYNC_STAGES flops per input plus SCLK rise/fall and CS fall/rise edge pulses. It is instantiated once.

## Test plan
- Write frame, header 0x80A5 with data 0x3C (master in write mode, addr 0x0A5) → a single `reg_wr_en` with `reg_addr`=0x0A5, `reg_wdata`=0x3C, then `frame_done`.
- Read frame, header 0x0037, model returns 0x5A → one `reg_rd_en` at addr 0x037, MISO shifts 0,1,0,1,1,0,1,0, and the master captures 0x5A.
- Multi-byte write, header 0xA100 (NB=2) with data 0x11,0x22,0x33 → writes 0x100←0x11, 0x0FF←0x22, 0x0FE←0x33.
- Multi-byte read at addr 0x000 with NB=1 → reads from 0x000 then 0x3FF, two `reg_rd_en` pulses, and 16 data bits on MISO.
- CS raised after 10 header bits, then after 20 bits of a write frame → `frame_err` each time, no `reg_wr_en`, and the next clean frame succeeds.
- `sys_nrst` pulsed mid-RD → `spi_miso_oe`=0 immediately, no `frame_done`, and the following write to 0x3FF completes.
